// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, response
// error codes, RISC-V funct3 encodings and the access-size mask helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Contiguous byte mask of the access size selected by funct3[1:0].
  function automatic logic [7:0] f3_byte_mask(input logic [2:0] f3);
    logic [7:0] m;
    case (f3[1:0])
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      2'b11:   m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational funct3 decode: legality, alignment, byte enables, store lane
// placement and load extraction/extension for an XLEN-wide memory word.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                       i_we,
  input  logic [2:0]                 i_funct3,
  input  logic [$clog2(XLEN/8)-1:0]  i_off,
  input  logic [XLEN-1:0]            i_wdata,
  input  logic [XLEN-1:0]            i_rdata,
  output logic                       o_legal,
  output logic                       o_aligned,
  output logic [XLEN/8-1:0]          o_be,
  output logic [XLEN-1:0]            o_wdata,
  output logic [XLEN-1:0]            o_ldata
);

  localparam int   NB   = XLEN / 8;
  localparam logic IS64 = 1'(XLEN == 64);

  logic [2:0]      w_off3;
  logic [XLEN-1:0] w_rsh;
  logic [63:0]     w_rsh64;
  logic [63:0]     w_ext64;

  assign w_off3  = 3'(i_off);
  assign w_rsh   = i_rdata >> {i_off, 3'b000};
  assign w_rsh64 = 64'(w_rsh);

  // Legality depends on direction and on whether 64-bit encodings exist.
  always_comb begin
    o_legal = 1'b0;
    case (i_funct3)
      F3_B, F3_H, F3_W: o_legal = 1'b1;
      F3_D:             o_legal = IS64;
      F3_BU, F3_HU:     o_legal = ~i_we;
      F3_WU:            o_legal = ~i_we & IS64;
      default:          o_legal = 1'b0;
    endcase
  end

  // Natural alignment check on the byte offset within the word.
  always_comb begin
    o_aligned = 1'b1;
    case (i_funct3[1:0])
      2'b00:   o_aligned = 1'b1;
      2'b01:   o_aligned = (w_off3[0] == 1'b0);
      2'b10:   o_aligned = (w_off3[1:0] == 2'b00);
      2'b11:   o_aligned = (w_off3 == 3'b000);
      default: o_aligned = 1'b1;
    endcase
  end

  // Byte enables and store data placed into their lanes.
  always_comb begin
    o_be    = NB'(NB'(f3_byte_mask(i_funct3)) << i_off);
    o_wdata = i_wdata << {i_off, 3'b000};
  end

  // Extension is computed at 64 bits and truncated so one table serves both widths.
  always_comb begin
    w_ext64 = 64'h0;
    case (i_funct3)
      F3_B:    w_ext64 = {{56{w_rsh64[7]}},  w_rsh64[7:0]};
      F3_H:    w_ext64 = {{48{w_rsh64[15]}}, w_rsh64[15:0]};
      F3_W:    w_ext64 = {{32{w_rsh64[31]}}, w_rsh64[31:0]};
      F3_D:    w_ext64 = w_rsh64;
      F3_BU:   w_ext64 = {56'h0, w_rsh64[7:0]};
      F3_HU:   w_ext64 = {48'h0, w_rsh64[15:0]};
      F3_WU:   w_ext64 = {32'h0, w_rsh64[31:0]};
      default: w_ext64 = 64'h0;
    endcase
    o_ldata = w_ext64[XLEN-1:0];
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core access at a time, runs the variable-latency
// memory handshake with a timeout, and returns extended data or a fault code.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [XLEN-1:0]   i_req_wdata,
  output logic              o_rsp_valid,
  output logic [XLEN-1:0]   o_rsp_rdata,
  output logic [1:0]        o_rsp_err,
  output logic              o_stall,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [XLEN/8-1:0] o_mem_be,
  input  logic              i_mem_ack,
  input  logic [XLEN-1:0]   i_mem_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  lsu_state_e r_state;
  lsu_state_e w_next;

  logic              r_we;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [7:0]        r_cnt;
  logic [XLEN-1:0]   r_rdata;
  logic [1:0]        r_err;

  logic              w_idle;
  logic              w_in_req;
  logic              w_accept;
  logic              w_cnt_last;
  logic              w_a_we;
  logic [2:0]        w_a_f3;
  logic [OFF_W-1:0]  w_a_off;
  logic [XLEN-1:0]   w_a_wdata;
  logic              w_legal;
  logic              w_aligned;
  logic [NB-1:0]     w_be;
  logic [XLEN-1:0]   w_sdata;
  logic [XLEN-1:0]   w_ldata;

  assign w_idle     = (r_state == IDLE);
  assign w_in_req   = (r_state == REQ);
  assign w_accept   = w_idle & i_req_valid;
  assign w_cnt_last = (r_cnt == 8'(TIMEOUT - 1));

  // The decoder sees the live request while idle and the latched one afterwards.
  assign w_a_we    = w_idle ? i_req_we                 : r_we;
  assign w_a_f3    = w_idle ? i_req_funct3             : r_f3;
  assign w_a_off   = w_idle ? i_req_addr[OFF_W-1:0]    : r_addr[OFF_W-1:0];
  assign w_a_wdata = w_idle ? i_req_wdata              : r_wdata;

  lsu_align #(.XLEN(XLEN)) u_align (
    .i_we      (w_a_we),
    .i_funct3  (w_a_f3),
    .i_off     (w_a_off),
    .i_wdata   (w_a_wdata),
    .i_rdata   (i_mem_rdata),
    .o_legal   (w_legal),
    .o_aligned (w_aligned),
    .o_be      (w_be),
    .o_wdata   (w_sdata),
    .o_ldata   (w_ldata)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; ack takes priority over the timeout in the last REQ cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          if (!w_legal || !w_aligned) begin
            w_next = RESP;
          end else begin
            w_next = REQ;
          end
        end else begin
          w_next = IDLE;
        end
      end
      REQ: begin
        if (i_mem_ack || w_cnt_last) begin
          w_next = RESP;
        end else begin
          w_next = REQ;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request latches, timeout counter and registered response fields.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= {ADDR_W{1'b0}};
      r_wdata <= {XLEN{1'b0}};
      r_cnt   <= 8'd0;
      r_rdata <= {XLEN{1'b0}};
      r_err   <= ERR_OK;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we    <= i_req_we;
            r_f3    <= i_req_funct3;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_cnt   <= 8'd0;
            if (!w_legal) begin
              r_err   <= ERR_ILLEGAL;
              r_rdata <= {XLEN{1'b0}};
            end else if (!w_aligned) begin
              r_err   <= ERR_MISALIGN;
              r_rdata <= {XLEN{1'b0}};
            end
          end
        end
        REQ: begin
          if (i_mem_ack) begin
            r_err   <= ERR_OK;
            r_rdata <= r_we ? {XLEN{1'b0}} : w_ldata;
            r_cnt   <= 8'd0;
          end else if (w_cnt_last) begin
            r_err   <= ERR_TIMEOUT;
            r_rdata <= {XLEN{1'b0}};
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign o_req_ready = w_idle;
  assign o_stall     = ~w_idle | (i_req_valid & w_idle);
  assign o_rsp_valid = (r_state == RESP);
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;

  // Memory-side signals are zero outside REQ so nothing leaks while idle or in reset.
  assign o_mem_req   = w_in_req;
  assign o_mem_we    = w_in_req & r_we;
  assign o_mem_addr  = w_in_req ? {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : {ADDR_W{1'b0}};
  assign o_mem_be    = w_in_req ? w_be    : {NB{1'b0}};
  assign o_mem_wdata = w_in_req ? w_sdata : {XLEN{1'b0}};

endmodule
